// File: rtl/period_averager_pkg.sv
// Shared constants and fill-state encoding for the period averager.
package period_averager_pkg;
    localparam int PERIOD_W  = 20;
    localparam int WIN_DEPTH = 4;
    localparam int WIN_LOG2  = 2;
    localparam int SUM_W     = 22;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } fill_state_t;
endpackage

// File: rtl/period_window.sv
// Four-entry circular sample window with running sum and fill-state tracking.
module period_window
    import period_averager_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                accept,
    input  logic [PERIOD_W-1:0] sample,
    output logic [SUM_W-1:0]    sum,
    output fill_state_t         state
);
    logic [PERIOD_W-1:0] slots [WIN_DEPTH];
    logic [WIN_LOG2-1:0] wr_ptr;
    logic [WIN_LOG2:0]   fill;
    logic [PERIOD_W-1:0] evicted;
    fill_state_t         state_next;

    // Once full, wr_ptr always points at the oldest entry, so it is the one evicted.
    assign evicted = (fill == (WIN_LOG2+1)'(WIN_DEPTH)) ? slots[wr_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIN_DEPTH; i++) slots[i] <= '0;
            wr_ptr <= '0;
            fill   <= '0;
            sum    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            fill   <= '0;
            sum    <= '0;
        end else if (accept) begin
            slots[wr_ptr] <= sample;
            wr_ptr        <= wr_ptr + 1'b1;
            if (fill != (WIN_LOG2+1)'(WIN_DEPTH)) fill <= fill + 1'b1;
            sum <= sum + SUM_W'(sample) - SUM_W'(evicted);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else if (accept) begin
            case (state)
                EMPTY:   state_next = FILLING;
                FILLING: if (fill == (WIN_LOG2+1)'(WIN_DEPTH-1)) state_next = FULL;
                default: state_next = FULL;
            endcase
        end
    end
endmodule

// File: rtl/period_averager.sv
// Averages the last four valid period samples; tracks min/max and flags stale input.
module period_averager
    import period_averager_pkg::*;
#(
    parameter int counter_max = 100000,
    parameter int timeout_max = 200000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                period_valid,
    input  logic                clear,
    output logic [PERIOD_W-1:0] avg_out,
    output logic                avg_valid,
    output logic [PERIOD_W-1:0] min_out,
    output logic [PERIOD_W-1:0] max_out,
    output logic                stale
);
    logic [PERIOD_W-1:0] timer;
    logic [SUM_W-1:0]    sum;
    fill_state_t         state;
    logic                saturated, accept, timeout, flush, first;

    assign saturated = period_valid && !clear && (period_in >= PERIOD_W'(counter_max));
    assign accept    = period_valid && !clear && (period_in <  PERIOD_W'(counter_max));
    // Timeout fires on the idle cycle that drives the timer onto timeout_max; a strobe there wins.
    assign timeout   = !period_valid && (timer >= PERIOD_W'(timeout_max - 1));
    assign flush     = clear || saturated || timeout;
    assign first     = (state == EMPTY);

    period_window u_window (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .accept (accept),
        .sample (period_in),
        .sum    (sum),
        .state  (state)
    );

    assign avg_out   = sum[SUM_W-1:WIN_LOG2];
    assign avg_valid = (state == FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (period_valid) begin
            timer <= '0;
        end else if (timer != PERIOD_W'(timeout_max)) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            min_out <= '0;
            max_out <= '0;
            stale   <= 1'b0;
        end else if (flush) begin
            min_out <= '0;
            max_out <= '0;
            if (saturated || timeout) stale <= 1'b1;
        end else if (accept) begin
            if (first || period_in < min_out) min_out <= period_in;
            if (first || period_in > max_out) max_out <= period_in;
            stale <= 1'b0;
        end
    end
endmodule

// File: tb/tb_period_averager.sv
// Scoreboarded bench: a behavioural model predicts each cycle's outputs.
module tb_period_averager;
    localparam int CMAX = 100000;
    localparam int TMAX = 40;

    logic        clk = 1'b0;
    logic        reset, period_valid, clear;
    logic [19:0] period_in;
    logic [19:0] avg_out, min_out, max_out;
    logic        avg_valid, stale;

    typedef struct {
        int avg;
        int vld;
        int mn;
        int mx;
        int stl;
    } exp_t;

    exp_t exp_q[$];
    int   win[$];
    int   m_min, m_max, m_stale, m_timer;
    int   n_tests = 0;
    int   n_fail  = 0;

    period_averager #(.counter_max(CMAX), .timeout_max(TMAX)) dut (
        .clk          (clk),
        .reset        (reset),
        .period_in    (period_in),
        .period_valid (period_valid),
        .clear        (clear),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid),
        .min_out      (min_out),
        .max_out      (max_out),
        .stale        (stale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_flush();
        win.delete();
        m_min = 0;
        m_max = 0;
    endtask

    // Model one clock edge and push the predicted outputs.
    task automatic model(input bit rst, input bit pv, input int d, input bit clr);
        exp_t e;
        int   s;
        if (rst) begin
            m_flush();
            m_stale = 0;
            m_timer = 0;
        end else if (pv) begin
            m_timer = 0;
            if (clr) m_flush();
            else if (d >= CMAX) begin
                m_flush();
                m_stale = 1;
            end else begin
                if (win.size() == 0) begin
                    m_min = d;
                    m_max = d;
                end else begin
                    if (d < m_min) m_min = d;
                    if (d > m_max) m_max = d;
                end
                win.push_back(d);
                if (win.size() > 4) void'(win.pop_front());
                m_stale = 0;
            end
        end else begin
            if (m_timer >= TMAX - 1) begin
                m_flush();
                m_stale = 1;
            end else if (clr) m_flush();
            if (m_timer < TMAX) m_timer++;
        end
        s = 0;
        foreach (win[i]) s += win[i];
        e.avg = s / 4;
        e.vld = (win.size() == 4);
        e.mn  = m_min;
        e.mx  = m_max;
        e.stl = m_stale;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit rst, input bit pv, input int d, input bit clr);
        exp_t e;
        reset        = rst;
        period_valid = pv;
        period_in    = 20'(d);
        clear        = clr;
        model(rst, pv, d, clr);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("avg_out", 32'(avg_out), 32'(e.avg));
        chk("avg_valid", 32'(avg_valid), 32'(e.vld));
        chk("min_out", 32'(min_out), 32'(e.mn));
        chk("max_out", 32'(max_out), 32'(e.mx));
        chk("stale", 32'(stale), 32'(e.stl));
        reset        = 1'b0;
        period_valid = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic strobe(input int d);
        step(0, 1, d, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; period_valid = 1'b0; clear = 1'b0; period_in = '0;
        m_flush(); m_stale = 0; m_timer = 0;
        step(1, 0, 0, 0);
        chk("reset_avg", 32'(avg_out), 0);
        chk("reset_stale", 32'(stale), 0);

        // 100,200,300,400 then 800
        strobe(100); strobe(200); strobe(300);
        chk("pre_full_valid", 32'(avg_valid), 0);
        strobe(400);
        chk("avg_250", 32'(avg_out), 250);
        chk("valid_after_4", 32'(avg_valid), 1);
        chk("min_100", 32'(min_out), 100);
        chk("max_400", 32'(max_out), 400);
        strobe(800);
        chk("avg_425", 32'(avg_out), 425);
        chk("max_800", 32'(max_out), 800);
        chk("valid_stays", 32'(avg_valid), 1);

        // truncation
        step(0, 0, 0, 1);
        strobe(1); strobe(1); strobe(1); strobe(2);
        chk("avg_trunc", 32'(avg_out), 1);

        // saturated sample flushes, next sample restarts
        strobe(10); strobe(20); strobe(30);
        strobe(CMAX);
        chk("sat_stale", 32'(stale), 1);
        chk("sat_valid", 32'(avg_valid), 0);
        chk("sat_max", 32'(max_out), 0);
        strobe(50);
        chk("post_sat_stale", 32'(stale), 0);
        chk("post_sat_min", 32'(min_out), 50);
        chk("post_sat_max", 32'(max_out), 50);
        chk("post_sat_valid", 32'(avg_valid), 0);

        // strobe on the timeout cycle wins
        strobe(60); strobe(70); strobe(80);
        idle(TMAX - 1);
        chk("pre_timeout_stale", 32'(stale), 0);
        strobe(90);
        chk("timeout_race_valid", 32'(avg_valid), 1);
        chk("timeout_race_max", 32'(max_out), 90);

        // genuine timeout
        idle(TMAX - 1);
        chk("one_before_timeout", 32'(avg_valid), 1);
        idle(1);
        chk("timeout_stale", 32'(stale), 1);
        chk("timeout_valid", 32'(avg_valid), 0);
        idle(5);

        // clear beats a coincident strobe, stale untouched
        strobe(5); strobe(6);
        step(0, 1, 500, 1);
        chk("clear_max", 32'(max_out), 0);
        strobe(7);
        chk("after_clear_min", 32'(min_out), 7);
        chk("after_clear_avg", 32'(avg_out), 1);

        // reset mid-window
        strobe(1000); strobe(2000);
        step(1, 0, 0, 0);
        chk("midreset_avg", 32'(avg_out), 0);
        chk("midreset_max", 32'(max_out), 0);
        strobe(4); strobe(8); strobe(12); strobe(16);
        chk("post_reset_avg", 32'(avg_out), 10);

        // random traffic
        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 60)      strobe($urandom_range(0, 5000));
            else if (r < 63) strobe(CMAX + $urandom_range(0, 100));
            else if (r < 66) step(0, $urandom_range(0, 1), $urandom_range(0, 5000), 1);
            else if (r < 68) step(1, 0, 0, 0);
            else             idle($urandom_range(1, TMAX + 2));
        end

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/period_averager.md
PERIOD_AVERAGER -- requirements
Module: period_averager

Interface
REQ-001 The block SHALL have a parameter counter_max, default 100000, giving the saturation value of incoming period samples; any sample at or above it means "no edge seen".
REQ-002 The block SHALL have a parameter timeout_max, default 200000, giving the number of clk cycles without a sample after which the window is declared stale.
REQ-003 clk  input  1  single system clock; every register is updated on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 period_in  input  20  period measurement in clk cycles, taken from the upstream edge-period counter.
REQ-006 period_valid  input  1  one-cycle strobe, asserted in the same cycle that period_in presents a new measurement.
REQ-007 clear  input  1  synchronous flush of the window and of the min/max trackers.
REQ-008 avg_out  output  20  mean of the last 4 accepted samples.
REQ-009 avg_valid  output  1  high while the window holds 4 accepted samples.
REQ-010 min_out  output  20  smallest accepted sample since the last flush.
REQ-011 max_out  output  20  largest accepted sample since the last flush.
REQ-012 stale  output  1  high after a timeout or a saturated sample; cleared by the next accepted sample.

Function
REQ-013 A sample SHALL be accepted when period_valid=1, clear=0 and period_in < counter_max.
REQ-014 Accepted samples SHALL be written into a 4-entry circular buffer at wr_ptr (2 bits, wraps 3->0), and the oldest entry SHALL be overwritten once the buffer is full.
REQ-015 A 22-bit running sum SHALL be updated per acceptance as sum + new - evicted, where evicted = 0 while fill < 4; no overflow is possible.
REQ-016 avg_out SHALL equal sum[21:2] (truncating), registered, and SHALL update 1 clk cycle after the accepting strobe.
REQ-017 fill (0..4) SHALL increment per acceptance, saturate at 4, and avg_valid SHALL equal (fill==4), registered with the same latency as avg_out.
REQ-018 The fill states SHALL be EMPTY (fill=0) -> FILLING (fill 1..3) -> FULL (fill=4); a flush event SHALL return the block to EMPTY from any state.
REQ-019 min_out SHALL update on acceptance if the sample is smaller (or on the first sample after a flush), and max_out SHALL update likewise if the sample is larger; both SHALL have 1-cycle latency.
REQ-020 A 20-bit idle timer SHALL reset on every period_valid, increment otherwise, and saturate at timeout_max; reaching timeout_max SHALL be a flush event and set stale=1.
REQ-021 period_valid with period_in >= counter_max SHALL be a flush event, set stale=1 and reset the idle timer.
REQ-022 clear=1 SHALL be a flush event but SHALL leave stale unchanged.
REQ-023 A flush event SHALL set fill=0, sum=0, avg_valid=0, avg_out=0, min_out=0, max_out=0 and wr_ptr=0; buffer contents are don't-care.
REQ-024 When clear and period_valid coincide, clear SHALL win and the sample SHALL be discarded.
REQ-025 When a timeout and period_valid coincide, the sample SHALL win, the timer SHALL reset and no flush SHALL occur.
REQ-026 An accepted sample SHALL clear stale in the same update that writes it.

Reset
REQ-027 reset SHALL have priority over all inputs and SHALL zero every register (buffer, sum, wr_ptr, fill, idle timer) and every output (avg_out, avg_valid, min_out, max_out, stale).
REQ-028 reset asserted mid-window SHALL discard all samples, and the first accepted sample after reset SHALL be treated as sample 1 of a new window.

Structure
REQ-029 A shared package SHALL hold the 20-bit period width constant, the window depth (4) and its log2 (2), the sum width (22), and the fill-state enumeration (EMPTY, FILLING, FULL).
REQ-030 The circular buffer, pointer and running sum SHALL be one sub-module, period_window, and the timer, min/max and flush logic SHALL stay in the top level.

Verification
REQ-031 Strobes of 100, 200, 300, 400 -> avg_valid rises 1 cycle after the 4th strobe; avg_out=250, min_out=100, max_out=400.
REQ-032 Continue from REQ-031 with a strobe of 800 -> avg_out=425 (sum 1700), min_out=100, max_out=800, avg_valid stays 1.
REQ-033 Strobes of 1, 1, 1, 2 -> avg_out=1 (truncation of 5/4).
REQ-034 Full window, then a strobe with period_in=100000 -> stale=1, avg_valid=0, all outputs 0; next strobe of 50 -> stale=0, min_out=max_out=50, avg_valid=0.
REQ-035 Full window, then no strobe for 200000 cycles -> stale=1 and flush at the cycle the timer hits timeout_max; a strobe arriving on that same cycle -> no flush and the sample is accepted.
REQ-036 clear and a strobe of 500 in the same cycle -> sample discarded, fill=0; reset pulsed mid-window -> all outputs 0 on the next cycle.
